// File: rtl/moore_seq_det_pkg.sv
// Shared types for the 1-0-1-1 Moore sequence detector: state encoding and target pattern.
package moore_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4
  } state_e;

  // Oldest bit is PATTERN[3].
  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/moore_seq_det.sv
// Moore FSM detecting the overlapping serial pattern 1-0-1-1; y is high only in S4.
// Optional detection counter det_cnt is built when MOORE_SEQ_CNT_EN is defined.
module moore_seq_det
  import moore_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
)
(
  input  logic clk,
  input  logic rst_b,
  input  logic x,
  output logic y
`ifdef MOORE_SEQ_CNT_EN
  ,
  output logic [CNT_W-1:0] det_cnt
`endif
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each state advances when x matches the next pattern bit; otherwise fall back to the
  // longest suffix that is still a pattern prefix.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (x == PATTERN[3]) ? S1 : IDLE;
      S1:      state_d = (x == PATTERN[2]) ? S2 : S1;
      S2:      state_d = (x == PATTERN[1]) ? S3 : IDLE;
      S3:      state_d = (x == PATTERN[0]) ? S4 : S2;
      S4:      state_d = x ? S1 : S2;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    y = (state_q == S4);
  end

`ifdef MOORE_SEQ_CNT_EN
  logic [CNT_W-1:0] det_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      det_cnt_q <= '0;
    end else if (state_d == S4) begin
      det_cnt_q <= det_cnt_q + CNT_W'(1);
    end
  end

  assign det_cnt = det_cnt_q;
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Table-driven bench for moore_seq_det plus a hand-written mid-pattern reset sequence.
module tb_moore_seq_det;

  logic clk;
  logic rst_b;
  logic x;
  logic y;
`ifdef MOORE_SEQ_CNT_EN
  logic [7:0] det_cnt;
`endif

  moore_seq_det #(.CNT_W(8)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .x    (x),
    .y    (y)
`ifdef MOORE_SEQ_CNT_EN
    ,
    .det_cnt(det_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic xin;
    logic exp_y;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_err;

  // Apply one edge of stimulus and check y (and det_cnt when built) just after the edge.
  task automatic step(input logic r, input logic xi, input logic ey, input int ec,
                      input string name);
    @(negedge clk);
    rst_b = r;
    x     = xi;
    @(posedge clk);
    #1;
    n_cmp++;
    if (y !== ey) begin
      n_err++;
      $display("FAIL %s: y got %b expected %b", name, y, ey);
    end
`ifdef MOORE_SEQ_CNT_EN
    n_cmp++;
    if (det_cnt !== 8'(ec)) begin
      n_err++;
      $display("FAIL %s: det_cnt got %0d expected %0d", name, det_cnt, ec);
    end
`else
    if (ec < 0) $display("negative count in table");
`endif
  endtask

  task automatic add(input logic r, input logic xi, input logic ey, input int ec);
    vec_t v;
    v.rst = r; v.xin = xi; v.exp_y = ey; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_b = 1'b1;
    x     = 1'b1;

    // Reset held for two edges with x=1.
    add(1, 1, 0, 0); add(1, 1, 0, 0);
    // Basic match 0,1,0,1,1 then one more bit to see the pulse drop.
    add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
    add(0, 1, 1, 1); add(0, 0, 0, 1);
    // Full stream: pulses after bits 4 and 15.
    add(1, 0, 0, 0);
    add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
    add(0, 1, 1, 1); add(0, 1, 0, 1); add(0, 1, 0, 1); add(0, 0, 0, 1);
    add(0, 0, 0, 1); add(0, 1, 0, 1); add(0, 1, 0, 1); add(0, 1, 0, 1);
    add(0, 1, 0, 1); add(0, 0, 0, 1); add(0, 1, 0, 1); add(0, 1, 1, 2);
    add(0, 0, 0, 2);
    // Overlap 1,0,1,1,0,1,1: pulses after bits 3 and 6.
    add(1, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 1);
    add(0, 0, 0, 1); add(0, 1, 0, 1); add(0, 1, 1, 2);
    // Near misses 1,0,0,1,1,1,0,1,0,1,1: single pulse at the end.
    add(1, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
    add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
    add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].xin, vecs[i].exp_y, vecs[i].exp_cnt, $sformatf("vec%0d", i));
    end

    // Mid-pattern reset: partial "101" is discarded, so the following 1 only reaches S1.
    step(1, 0, 0, 0, "mid_rst_pre");
    step(0, 1, 0, 0, "mid_b0");
    step(0, 0, 0, 0, "mid_b1");
    step(0, 1, 0, 0, "mid_b2");
    step(1, 1, 0, 0, "mid_rst");
    step(0, 1, 0, 0, "mid_after_rst");
    step(0, 0, 0, 0, "mid_b4");
    step(0, 1, 0, 0, "mid_b5");
    step(0, 1, 1, 1, "mid_match");
    step(0, 1, 0, 1, "mid_drop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation got stuck expected completion");
    $fatal(1);
  end

endmodule

// File: doc/moore_seq_det.md
Name:
moore_seq_det

Overview:
- Serial bit-stream pattern detector built as a Moore finite-state machine.
- Samples input `x` on each rising edge of `clk`.
- Asserts `y` while the FSM is in the "pattern complete" state.
- Detects the fixed pattern 1-0-1-1, oldest bit first, with overlapping matches allowed.
- Used as a leaf block in the control/detect datapath; both output paths are registered.

Parameters:
- CNT_W, default 8: width of the detection counter. Only used when MOORE_SEQ_CNT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_b  input  1  synchronous, active-high reset. When 1 at a rising clk edge, the FSM goes to IDLE. The port keeps the codebase name despite its polarity.
- x  input  1  serial data bit, sampled at each rising clk edge.
- y  output  1  detect flag; 1 exactly when the state is S4.
- det_cnt  output  CNT_W  detection count. Present only with MOORE_SEQ_CNT_EN.

Behaviour:
- States are encoded as a 3-bit enumerated type:
  - IDLE (nothing matched)
  - S1 ("1")
  - S2 ("10")
  - S3 ("101")
  - S4 ("1011", match)
- Reset: synchronous. When rst_b=1 at a rising edge:
  - state <= IDLE, so y = 0 from that edge onward.
  - det_cnt <= 0.
  - Reset has priority over x, including mid-pattern; a partial match is discarded.
- State transitions (next state for x=0 / x=1):
  - IDLE: x=0 -> IDLE, x=1 -> S1
  - S1: x=0 -> S2, x=1 -> S1
  - S2: x=0 -> IDLE, x=1 -> S3
  - S3: x=0 -> S2, x=1 -> S4
  - S4: x=0 -> S2 (overlap suffix "10"), x=1 -> S1 (overlap suffix "1")
- Output: y is a pure function of the state register (Moore): y = (state == S4).
  - No combinational path from x to y.
- Latency: y rises on the same rising edge that samples the 4th pattern bit, and stays high for exactly one clock period.
  - S4 never transitions to itself, so y is never high for two consecutive cycles.
- Overlap: after a match, the trailing "1" or "10" seeds the next match. Stream 1011011 therefore produces two pulses, three cycles apart.
- Illegal state encodings (values 5–7) must return to IDLE on the next edge, with y = 0.
- Between the edge that releases reset and the next edge, the FSM is in IDLE.

Optional Feature:
- Macro: MOORE_SEQ_CNT_EN.
- Defined:
  - Adds output det_cnt [CNT_W-1:0].
  - det_cnt increments by 1 on each edge where the next state is S4, so it updates together with the rise of y.
  - Wraps modulo 2^CNT_W.
  - Cleared by rst_b.
- Undefined:
  - Port and counter logic are absent.
  - y behaviour is identical in both builds.

Decomposition:
- Shared package moore_seq_pkg holds:
  - the state enum typedef (IDLE, S1..S4, 3-bit encoding)
  - the localparam PATTERN = 4'b1011
- Single module; no sub-module needed. Keep the next-state logic and the state register in separate always blocks inside moore_seq_det.

Test Plan:
1. Reset: hold rst_b=1 for 2 edges with x=1 -> y=0, state=IDLE, det_cnt=0.
2. Basic match:
   - Stimulus: release reset, drive x = 0,1,0,1,1 on successive edges.
   - Required: y=1 for exactly one cycle after the edge sampling the final 1 of "1011"; 0 otherwise.
3. Full stream:
   - Stimulus: x = 0,1,0,1,1,1,1,0,0,1,1,1,1,0,1,1,0 (one bit per edge).
   - Required: exactly two y pulses, after bit indices 4 and 15 (0-based); det_cnt=2 at the end.
4. Overlap: x = 1,0,1,1,0,1,1 -> y pulses after bits 3 and 6; det_cnt=2.
5. Near-misses: x = 1,0,0,1,1,1,0,1,0,1,1 -> the only pulse is after the final bit. Checks S2 x=0 -> IDLE and S3 x=0 -> S2.
6. Mid-pattern reset: drive 1,0,1, assert rst_b for 1 edge, then drive 1 -> no pulse. Then 0,1,1 -> pulse.
